// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the SRAM-like data-bus responder:
// transfer-size codes, the response-queue entry and the byte-strobe decoder.
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Wide enough for LATENCY-1 with LATENCY up to 7
    localparam int TIMER_W = 3;

    typedef struct packed {
        logic               is_wr;
        logic [31:0]        rdata;
        logic [TIMER_W-1:0] timer;
    } entry_t;

    // Misaligned or undefined sizes yield an empty strobe: the access is
    // still answered but nothing is written.
    function automatic logic [3:0] size_to_strobe(input logic [1:0] size,
                                                  input logic [1:0] addr_lo);
        logic [3:0] strobe;
        strobe = 4'b0000;
        case (size)
            SIZE_BYTE: strobe = 4'b0001 << addr_lo;
            SIZE_HALF: if (!addr_lo[0]) strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: if (addr_lo == 2'b00) strobe = 4'b1111;
            default:   strobe = 4'b0000;
        endcase
        return strobe;
    endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue: DEPTH entries, each with its own latency timer
// counting down in parallel. The head is always the oldest accepted request.
module sram_like_resp_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  logic        push_wr,
    input  logic [31:0] push_rdata,
    input  logic        pop,
    output logic [2:0]  count,
    output logic        head_valid,
    output logic        head_ready,
    output logic        head_wr,
    output logic [31:0] head_rdata
);

    entry_t     q     [DEPTH];
    entry_t     q_nxt [DEPTH];
    logic [2:0] count_nxt;
    logic [2:0] wr_idx;

    always_comb begin
        q_nxt = q;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_nxt[i].timer != '0) q_nxt[i].timer = q_nxt[i].timer - 1'b1;
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) q_nxt[i] = q_nxt[i+1];
        end
        // The push slot is computed after the pop shift.
        wr_idx = count - {2'b00, pop};
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (3'(i) == wr_idx) begin
                    q_nxt[i].is_wr = push_wr;
                    q_nxt[i].rdata = push_rdata;
                    q_nxt[i].timer = TIMER_W'(LATENCY - 1);
                end
            end
        end
        count_nxt = count + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) count <= 3'd0;
        else         count <= count_nxt;
    end

    // Payload storage is not reset; count alone decides which slots are live.
    always_ff @(posedge clk) begin
        q <= q_nxt;
    end

    assign head_valid = (count != 3'd0);
    assign head_ready = head_valid && (q[0].timer == '0);
    assign head_wr    = q[0].is_wr;
    assign head_rdata = q[0].rdata;

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like data bus: word RAM with byte-laned writes and
// fixed-latency in-order responses. Define SRAM_RESP_STALL_EN for LFSR stalls.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata
);

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] word_idx;
    logic [3:0]        strobe;
    logic              accept;
    logic              stall;
    logic [2:0]        fifo_count;
    logic              head_valid;
    logic              head_ready;
    logic              head_wr;
    logic [31:0]       head_rdata;
    logic              unused_addr;

    // Upper address bits alias onto the same RAM words.
    assign word_idx    = data_addr[ADDR_W+1:2];
    assign unused_addr = ^data_addr[31:ADDR_W+2] ^ head_valid;
    assign strobe      = size_to_strobe(data_size, data_addr[1:0]);

`ifdef SRAM_RESP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= 16'hACE1;
        else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // A slot freed by this cycle's pop is not offered until the next cycle.
    assign data_addr_ok = resetn && data_req && (fifo_count < 3'(DEPTH)) && !stall;
    assign accept       = data_addr_ok;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (accept && data_wr && strobe[b])
                mem[word_idx][8*b +: 8] <= data_wdata[8*b +: 8];
        end
    end

    sram_like_resp_fifo #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_wr    (data_wr),
        .push_rdata (data_wr ? 32'h0 : mem[word_idx]),
        .pop        (head_ready),
        .count      (fifo_count),
        .head_valid (head_valid),
        .head_ready (head_ready),
        .head_wr    (head_wr),
        .head_rdata (head_rdata)
    );

    assign data_data_ok = head_ready;
    assign data_rdata   = (head_ready && !head_wr) ? head_rdata : 32'h0;

endmodule
